// File: rtl/fir_pkg.sv
// Shared types for the FIR tap sequencer.
// Defining FIR_TAP_SEQ_FLUSH_EN adds the FLUSH state.
package fir_pkg;
  localparam int ALU_LAT_DEF = 5;
  localparam int IDX_W       = 6;  // wide enough for tap indices up to NTAPS=64

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_ADD = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_MUL, ST_DRAIN, ST_ADD, ST_AWAIT, ST_DONE
`ifdef FIR_TAP_SEQ_FLUSH_EN
    , ST_FLUSH
`endif
  } state_e;

  typedef struct packed {
    logic             valid;
    logic             op;
    logic [IDX_W-1:0] idx;
  } tag_t;
endpackage

// File: rtl/op_tracker.sv
// Shadow of the FPALU pipeline: one tag per issued op, emerging DEPTH cycles
// after issue. mul_pending excludes the stage retiring this cycle.
module op_tracker
  import fir_pkg::*;
#(
  parameter int DEPTH = ALU_LAT_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             in_op,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic             out_op,
  output logic [IDX_W-1:0] out_idx,
  output logic             mul_pending
);
  tag_t [DEPTH-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = '{valid: in_valid, op: in_op, idx: in_idx};
    for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
    if (clr) pipe_d = '0;
  end

  always_ff @(posedge clk) pipe_q <= pipe_d;

  always_comb begin
    mul_pending = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++)
      mul_pending = mul_pending | (pipe_q[i].valid & (pipe_q[i].op == OP_MUL));
  end

  assign out_valid = pipe_q[DEPTH-1].valid;
  assign out_op    = pipe_q[DEPTH-1].op;
  assign out_idx   = pipe_q[DEPTH-1].idx;
endmodule

// File: rtl/fir_tap_seq.sv
// FIR tap sequencer: writes a sample, issues NTAPS multiplies, then chains
// NTAPS dependent adds through the FPALU. FIR_TAP_SEQ_FLUSH_EN adds a flush port.
module fir_tap_seq
  import fir_pkg::*;
#(
  parameter  int NTAPS   = 16,
  parameter  int ALU_LAT = ALU_LAT_DEF,
  localparam int AW      = $clog2(NTAPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
`ifdef FIR_TAP_SEQ_FLUSH_EN
  input  logic          flush,
`endif
  output logic          s_ready,
  output logic          smp_we,
  output logic [AW-1:0] smp_waddr,
  output logic [AW-1:0] smp_raddr,
  output logic [AW-1:0] coef_raddr,
  output logic          prod_we,
  output logic [AW-1:0] prod_waddr,
  output logic [AW-1:0] prod_raddr,
  output logic          alu_issue,
  output logic          alu_add_muln,
  output logic          alu_b_zero,
  output logic          acc_we,
  output logic          y_valid,
  output logic          busy
);
  localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] cnt_q, cnt_d;

  logic             tag_in_op, ret_valid, ret_op, mul_pending;
  logic [IDX_W-1:0] ret_idx;
  logic             unused_ret_idx;

  op_tracker #(.DEPTH(ALU_LAT)) u_trk (
    .clk        (clk),
    .clr        (rst),
    .in_valid   (alu_issue),
    .in_op      (tag_in_op),
    .in_idx     (IDX_W'(cnt_q)),
    .out_valid  (ret_valid),
    .out_op     (ret_op),
    .out_idx    (ret_idx),
    .mul_pending(mul_pending)
  );
  // upper index bits only carry information when NTAPS = 64
  assign unused_ret_idx = ^ret_idx;

  assign tag_in_op  = alu_add_muln;
  assign prod_we    = ret_valid & (ret_op == OP_MUL);
  assign acc_we     = ret_valid & (ret_op == OP_ADD);
  assign prod_waddr = prod_we ? ret_idx[AW-1:0] : '0;
  assign busy       = (state_q != ST_IDLE);

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    base_d       = base_q;
    cnt_d        = cnt_q;
    s_ready      = 1'b0;
    smp_we       = 1'b0;
    smp_waddr    = '0;
    smp_raddr    = '0;
    coef_raddr   = '0;
    prod_raddr   = '0;
    alu_issue    = 1'b0;
    alu_add_muln = 1'b0;
    alu_b_zero   = 1'b0;
    y_valid      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
`ifdef FIR_TAP_SEQ_FLUSH_EN
        s_ready = ~flush;
        if (flush) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end else
`else
        s_ready = 1'b1;
`endif
        if (s_valid) begin
          base_d  = wr_ptr_q;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        smp_we    = 1'b1;
        smp_waddr = base_q;
        wr_ptr_d  = wr_ptr_q + 1'b1;
        cnt_d     = '0;
        state_d   = ST_MUL;
      end
      ST_MUL: begin
        alu_issue  = 1'b1;
        coef_raddr = cnt_q;
        smp_raddr  = base_q - cnt_q;
        cnt_d      = cnt_q + 1'b1;  // wraps to 0, ready for the add phase
        if (cnt_q == LAST) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (!mul_pending) state_d = ST_ADD;
      ST_ADD: begin
        alu_issue    = 1'b1;
        alu_add_muln = 1'b1;
        prod_raddr   = cnt_q;
        alu_b_zero   = (cnt_q == '0);
        state_d      = ST_AWAIT;
      end
      ST_AWAIT: begin
        if (acc_we) begin
          if (cnt_q == LAST) state_d = ST_DONE;
          else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = ST_ADD;
          end
        end
      end
      ST_DONE: begin
        y_valid = 1'b1;
        state_d = ST_IDLE;
      end
`ifdef FIR_TAP_SEQ_FLUSH_EN
      ST_FLUSH: begin
        smp_we    = 1'b1;
        smp_waddr = cnt_q;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          wr_ptr_d = '0;
          state_d  = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      base_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      base_q   <= base_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule
